// File: rtl/ysyx_25050148_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_25050148_ifu -- instruction fetch unit
//
// Purpose:
//   Fetches one instruction per loop from an instruction memory using a
//   valid/ready request channel and a valid-only response channel. The fetched
//   word and its address are presented to decode. The unit then waits for
//   write-back to supply the next PC before it issues another request.
//   Loop: IDLE (once after reset) -> REQ -> WAIT -> VALID -> NEXT -> REQ ...
//   With zero memory wait states, the unit fetches one instruction every
//   four cycles.
//
// Parameters:
//   RESET_PC        PC value loaded by reset (default 32'h80000000)
//
// Ports:
//   clk             single clock, rising edge
//   rst             asynchronous, active-low reset
//   imem_req_valid  fetch request present (REQ state only)
//   imem_req_ready  memory accepts the request
//   imem_req_addr   fetch address (always the current pc)
//   imem_resp_valid returned instruction data valid (honoured in WAIT only)
//   imem_resp_data  returned instruction word
//   inst_valid      pc/instruction hold a fetched instruction (VALID only)
//   inst_ready      decode accepts the instruction
//   pc              address of the current instruction
//   instruction     registered fetched word
//   npc_valid       next PC from write-back available (honoured in NEXT only)
//   npc             next PC
//   fetch_fault     misaligned next PC was loaded (alignment check build only)
//
// Configuration:
//   YSYX_25050148_IFU_ALIGN_CHECK_EN
//     When defined, a next PC with npc[1:0] != 0 is still loaded, but it
//     raises fetch_fault and parks the unit in FAULT until reset.
//     When undefined, there is no FAULT state, fetch_fault is tied low, and
//     npc is loaded unchecked.
// ----------------------------------------------------------------------------
module ysyx_25050148_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fetch_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
`ifdef YSYX_25050148_IFU_ALIGN_CHECK_EN
  localparam logic [2:0] S_FAULT = 3'd5;
`endif

  // RISC-V canonical nop (addi x0, x0, 0) shown to decode after reset.
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  // Handshake qualifiers. Each input is only honoured in its own state, so a
  // stray response or next-PC pulse elsewhere in the loop is ignored.
  logic req_fire;
  logic resp_take;
  logic inst_fire;
  logic npc_take;
  logic npc_misaligned;

  assign req_fire       = (state == S_REQ)   && imem_req_ready;
  assign resp_take      = (state == S_WAIT)  && imem_resp_valid;
  assign inst_fire      = (state == S_VALID) && inst_ready;
  assign npc_take       = (state == S_NEXT)  && npc_valid;
  assign npc_misaligned = (npc[1:0] != 2'b00);

  // Next-state logic for the fetch loop. IDLE always lasts a single cycle,
  // so a response that arrives during it (for example, left over from a
  // transaction abandoned by reset) can never be mistaken for fresh data.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ:   if (req_fire)  state_next = S_WAIT;
      S_WAIT:  if (resp_take) state_next = S_VALID;
      S_VALID: if (inst_fire) state_next = S_NEXT;
      S_NEXT: begin
        if (npc_take) begin
`ifdef YSYX_25050148_IFU_ALIGN_CHECK_EN
          if (npc_misaligned) begin
            state_next = S_FAULT;
          end else begin
            state_next = S_REQ;
          end
`else
          state_next = S_REQ;
`endif
        end
      end
`ifdef YSYX_25050148_IFU_ALIGN_CHECK_EN
      // FAULT holds until reset: no requests and no instructions.
      S_FAULT: state_next = S_FAULT;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The PC only moves when write-back hands over a next PC in NEXT. It stays
  // untouched while a request is stalled, so imem_req_addr is stable in REQ.
  // A misaligned npc is loaded as well, so the faulting address is visible
  // on pc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (npc_take) begin
      pc_q <= npc;
    end
  end

  // Instruction register. Data is captured only in WAIT, so the word shown
  // to decode cannot change while it is being offered in VALID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q <= NOP_INST;
    end else if (resp_take) begin
      inst_q <= imem_resp_data;
    end
  end

`ifdef YSYX_25050148_IFU_ALIGN_CHECK_EN
  logic fault_q;

  // Sticky fault flag. It is raised with the same edge that enters FAULT,
  // and only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else if (npc_take && npc_misaligned) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_align;

  assign unused_align = npc_misaligned;
  assign fetch_fault  = 1'b0;
`endif

  // Outputs are decoded from registered state only. They do not depend
  // combinationally on rst or on any handshake input.
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state == S_VALID);
  assign pc             = pc_q;
  assign instruction    = inst_q;

endmodule

// File: tb/tb_ysyx_25050148_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25050148_ifu -- self-checking bench for ysyx_25050148_ifu
//
// Purpose:
//   Drives directed fetch transactions. Every time the driver issues a
//   request or a response, it pushes the hand-computed expectation into a
//   queue. A separate monitor pops and compares those entries whenever the
//   DUT completes a request or instruction handshake. Reset values, stall
//   stability, ignored stray inputs, and reset during a transaction are
//   checked directly by the driver.
//
// Ports: none (top-level bench).
//
// Configuration:
//   YSYX_25050148_IFU_ALIGN_CHECK_EN selects the expected behaviour for a
//   misaligned next PC (fault vs. plain fetch).
// ----------------------------------------------------------------------------
module tb_ysyx_25050148_ifu;

  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];
  logic [31:0] next_addr;

  ysyx_25050148_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .pc              (pc),
    .instruction     (instruction),
    .npc_valid       (npc_valid),
    .npc             (npc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic report_fail(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // The monitor samples on the falling edge, away from the capturing edge.
  // A handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) begin
          report_fail("unexpected_req", imem_req_addr, 32'h0);
        end else begin
          check_output("req_addr", imem_req_addr, req_q.pop_front());
        end
      end
      if (inst_valid && inst_ready) begin
        if (inst_q.size() == 0) begin
          report_fail("unexpected_inst", pc, 32'h0);
        end else begin
          logic [63:0] exp_inst;
          exp_inst = inst_q.pop_front();
          check_output("inst_pc", pc, exp_inst[63:32]);
          check_output("inst_word", instruction, exp_inst[31:0]);
        end
      end
    end
  end

  // The driver tasks below start and end one time unit after a rising edge.
  task automatic do_request(input logic [31:0] addr);
    bit done;
    done = 1'b0;
    req_q.push_back(addr);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (imem_req_valid) done = 1'b1;
    end
    if (!done) report_fail("req_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
  endtask

  task automatic do_response(input logic [31:0] exp_pc, input logic [31:0] data);
    inst_q.push_back({exp_pc, data});
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  task automatic accept_inst();
    bit done;
    done = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (inst_valid) done = 1'b1;
    end
    if (!done) report_fail("inst_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic give_npc(input logic [31:0] addr);
    @(negedge clk);
    check_output("next_no_inst", {31'h0, inst_valid}, 32'h0);
    check_output("next_no_req", {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk); #1;
    npc_valid = 1'b1;
    npc       = addr;
    @(posedge clk); #1;
    npc_valid = 1'b0;
    npc       = 32'h0;
  endtask

  initial begin
    $display("[TB] start");

    // Reset held: outputs must sit at their cleared values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      check_output("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    end
    check_output("rst_pc", pc, RESET_PC);
    check_output("rst_instruction", instruction, NOP_INST);
    check_output("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // Release: one IDLE cycle, then a request to RESET_PC that stays stable
    // while memory holds ready low for five cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("idle_no_req", {31'h0, imem_req_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check_output("stall_req_addr", imem_req_addr, RESET_PC);
    end
    @(posedge clk); #1;

    do_request(RESET_PC);
    do_response(RESET_PC, 32'h00100093);

    // Decode stalls for three cycles. A stray response and an npc pulse
    // arrive during VALID and must leave pc/instruction untouched.
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("hold_inst_valid", {31'h0, inst_valid}, 32'h1);
      check_output("hold_pc", pc, RESET_PC);
      check_output("hold_instruction", instruction, 32'h00100093);
      imem_resp_valid = (i == 0);
      imem_resp_data  = (i == 0) ? 32'hDEADBEEF : 32'h0;
      npc_valid       = (i == 1);
      npc             = (i == 1) ? 32'h12345678 : 32'h0;
    end
    imem_resp_valid = 1'b0;
    npc_valid       = 1'b0;
    @(posedge clk); #1;
    accept_inst();
    give_npc(32'h80000010);

    do_request(32'h80000010);
    do_response(32'h80000010, 32'h00200113);
    accept_inst();
    give_npc(32'h80000006);

`ifdef YSYX_25050148_IFU_ALIGN_CHECK_EN
    // Misaligned next PC: the unit parks in FAULT and issues nothing, even
    // with memory ready (the monitor flags any request as unexpected).
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("fault_flag", {31'h0, fetch_fault}, 32'h1);
      check_output("fault_no_req", {31'h0, imem_req_valid}, 32'h0);
      check_output("fault_no_inst", {31'h0, inst_valid}, 32'h0);
      check_output("fault_pc", pc, 32'h80000006);
    end
    imem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("fault_cleared", {31'h0, fetch_fault}, 32'h0);
    check_output("fault_rst_pc", pc, RESET_PC);
    @(posedge clk); #1;
    rst = 1'b1;
    do_request(RESET_PC);
    do_response(RESET_PC, 32'h00300193);
    accept_inst();
    give_npc(32'h80000020);
`else
    // Without the alignment check, the misaligned PC is simply fetched.
    do_request(32'h80000006);
    do_response(32'h80000006, 32'h00300193);
    accept_inst();
    check_output("no_fault", {31'h0, fetch_fault}, 32'h0);
    give_npc(32'h80000020);
`endif
    next_addr = 32'h80000020;

    // Reset while in WAIT. A response shows up one cycle after release and
    // must be ignored; the unit then requests RESET_PC again.
    do_request(next_addr);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_output("midrst_pc", pc, RESET_PC);
    check_output("midrst_instruction", instruction, NOP_INST);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBADC0DE0;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    @(negedge clk);
    check_output("late_resp_ignored", instruction, NOP_INST);
    check_output("refetch_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_output("refetch_addr", imem_req_addr, RESET_PC);
    @(posedge clk); #1;
    do_request(RESET_PC);
    do_response(RESET_PC, 32'h00400213);
    accept_inst();

    repeat (2) @(posedge clk);
    check_output("req_queue_empty", req_q.size(), 32'h0);
    check_output("inst_queue_empty", inst_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always ends with a summary line.
  initial begin
    #20000;
    report_fail("watchdog", 32'h0, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
